pc_step_ctrl: RTL
=================

Name: pc_step_ctrl

Overview:
- Control stage directly upstream of the program counter; drives `PCincr` each cycle.
- Decodes the current opcode, read combinationally from program memory at the PC address.
- Synchronises and debounces the raw `SW8` handshake switch.
- Stalls the PC on wait-for-switch instructions and halts permanently on HALT. Also produces an input-load strobe for the register file.

Parameters:
- DB_LEN, 4: consecutive cycles the synchronised switch must differ from the debounced value before the debounced value changes (minimum 1).
- OP_W, 3: opcode width.
- OP_WAITH, 3'b110: stall until debounced SW8 = 1, then pulse `in_load`.
- OP_WAITL, 3'b111: stall until debounced SW8 = 0.
- OP_HALT, 3'b101: stop the PC until reset.

Ports:
- clk, in, 1: system clock; all state on the rising edge.
- reset_n, in, 1: reset; asynchronous, active-low.
- SW8, in, 1: raw handshake switch, asynchronous to clk.
- opcode, in, OP_W: opcode of the instruction at the current PC.
- PCincr, out, 1: PC advance enable, sampled by the PC on the next rising edge.
- in_load, out, 1: one-cycle strobe; latch external input data.
- waiting, out, 1: FSM is in WAIT_HI or WAIT_LO.
- halted, out, 1: FSM is in HALTED.
- sw_db, out, 1: debounced switch level.

Behaviour:
- Reset (async, reset_n = 0):
  - sync flops s1 and s2 = 0; sw_db = 0; debounce counter = 0; state = RUN.
  - PCincr, in_load, waiting, halted are all forced to 0 while reset_n = 0, regardless of opcode.
- Synchroniser:
  - 2-flop chain: s1 <= SW8, s2 <= s1.
- Debounce:
  - If s2 == sw_db, counter <= 0.
  - Otherwise counter increments. When counter == DB_LEN-1 and s2 still differs, sw_db <= s2 and counter <= 0.
  - Latency from a stable SW8 change to sw_db change: DB_LEN+2 rising edges.
  - A pulse shorter than DB_LEN cycles at s2 never reaches sw_db.
  - Counter width is clog2(DB_LEN)+1 bits and never wraps.
- FSM states: RUN, WAIT_HI, WAIT_LO, HALTED. Registered state. All outputs are combinational from state, opcode and sw_db.
- RUN:
  - opcode == OP_HALT: PCincr = 0; next = HALTED.
  - opcode == OP_WAITH:
    - sw_db = 1: PCincr = 1, in_load = 1, stay in RUN (pass-through, no stall cycle).
    - sw_db = 0: PCincr = 0; next = WAIT_HI.
  - opcode == OP_WAITL:
    - sw_db = 0: PCincr = 1, stay in RUN.
    - sw_db = 1: PCincr = 0; next = WAIT_LO.
  - Any other opcode: PCincr = 1.
- WAIT_HI:
  - Opcode is ignored.
  - sw_db = 0: PCincr = 0, in_load = 0, stay.
  - sw_db = 1: PCincr = 1 and in_load = 1 in that same cycle; next = RUN.
- WAIT_LO:
  - Opcode is ignored.
  - sw_db = 1: PCincr = 0, stay.
  - sw_db = 0: PCincr = 1; next = RUN.
- HALTED:
  - PCincr = 0, halted = 1.
  - Only reset exits; SW8 and opcode have no effect.
- in_load is asserted for exactly one cycle per completed WAITH instruction and in no other case.
- Simultaneous events: the sw_db update and the FSM decision in the same edge use the pre-edge sw_db. The wait exit is seen the cycle after sw_db changes.
- Reset mid-wait or mid-debounce: state returns to RUN, counter clears, sw_db = 0. No in_load pulse is produced by reset release.
- PC wrap-around is the PC's concern; this block imposes no address limit.

Test Plan:
- Reset: hold reset_n = 0 with opcode = 3'b000 and SW8 = 1 -> PCincr = 0, in_load = 0, sw_db = 0. Release -> PCincr = 1 on the first cycle; sw_db = 1 after 6 edges (DB_LEN = 4).
- WAITH stall: opcode = 3'b110, SW8 = 0 -> waiting = 1, PCincr = 0 indefinitely. Raise SW8 -> PCincr = 1 and in_load = 1 for exactly one cycle, 6 edges after the SW8 rise; waiting = 0 next cycle.
- Debounce reject: while in WAIT_HI, pulse SW8 high for 3 cycles -> sw_db stays 0, no PCincr, no in_load. A 4-cycle-stable pulse at s2 -> sw_db = 1.
- WAITL: opcode = 3'b111 with sw_db = 1 -> PCincr = 0, waiting = 1. Drop SW8 -> PCincr = 1 after 6 edges; in_load stays 0 throughout.
- Pass-through: opcode = 3'b110 with sw_db already 1 -> PCincr = 1 and in_load = 1 in the same cycle, waiting never asserted.
- HALT and reset mid-operation: opcode = 3'b101 -> halted = 1, PCincr = 0 while SW8 toggles. Assert reset_n = 0 mid-halt and mid-WAIT_HI -> state RUN, halted = 0, waiting = 0, no spurious in_load.

Source files
------------

// File: rtl/pc_step_ctrl.sv
// pc_step_ctrl: debounced SW8 handshake, wait/halt stalls and PC advance enable for the program counter
module pc_step_ctrl #(
    parameter int DB_LEN = 4,
    parameter int OP_W = 3,
    parameter logic [OP_W-1:0] OP_WAITH = 3'b110,
    parameter logic [OP_W-1:0] OP_WAITL = 3'b111,
    parameter logic [OP_W-1:0] OP_HALT = 3'b101
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            SW8,
    input  logic [OP_W-1:0] opcode,
    output logic            PCincr,
    output logic            in_load,
    output logic            waiting,
    output logic            halted,
    output logic            sw_db
);
    localparam int CW = $clog2(DB_LEN) + 1;
    typedef enum logic [1:0] {RUN, WAIT_HI, WAIT_LO, HALTED} state_t;
    state_t st, nxt;
    logic s1, s2, go, ld;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            sw_db <= 1'b0;
            cnt <= '0;
            st <= RUN;
        end else begin
            s1 <= SW8;
            s2 <= s1;
            st <= nxt;
            if (s2 == sw_db) cnt <= '0;
            else if (cnt == CW'(DB_LEN - 1)) begin
                sw_db <= s2;
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
    always_comb begin
        nxt = st;
        go = 1'b0;
        ld = 1'b0;
        case (st)
            RUN: begin
                if (opcode == OP_HALT) nxt = HALTED;
                else if (opcode == OP_WAITH) begin
                    go = sw_db;
                    ld = sw_db;
                    nxt = sw_db ? RUN : WAIT_HI;
                end else if (opcode == OP_WAITL) begin
                    go = !sw_db;
                    nxt = sw_db ? WAIT_LO : RUN;
                end else go = 1'b1;
            end
            WAIT_HI: begin
                go = sw_db;
                ld = sw_db;
                nxt = sw_db ? RUN : WAIT_HI;
            end
            WAIT_LO: begin
                go = !sw_db;
                nxt = sw_db ? WAIT_LO : RUN;
            end
            default: nxt = HALTED;
        endcase
    end
    // outputs are masked by reset_n so an opcode on the bus cannot move the PC during reset
    assign PCincr = reset_n & go;
    assign in_load = reset_n & ld;
    assign waiting = reset_n & (st == WAIT_HI || st == WAIT_LO);
    assign halted = reset_n & (st == HALTED);
endmodule
